// File: rtl/mole_scheduler_pkg.sv
// Shared types and helpers for the mole scheduler.
// State encoding, LFSR taps and the level-to-interval lookup.
package mole_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PROBE = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [8:0] spawn_interval(
        input logic [1:0] level,
        input logic [8:0] i0,
        input logic [8:0] i1,
        input logic [8:0] i2
    );
        case (level)
            2'd0:    return i0;
            2'd1:    return i1;
            default: return i2;
        endcase
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR.
// The low three bits pick the first hole to probe.
module mole_lfsr
    import mole_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] tap
);

    logic [15:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign tap = q[2:0];

endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: hole lifetimes, spawn timing and probing,
// and hit/miss classification of button presses.
module mole_scheduler
    import mole_scheduler_pkg::*;
#(
    parameter int          SPAWN_L0    = 300,
    parameter int          SPAWN_L1    = 250,
    parameter int          SPAWN_L2    = 150,
    parameter int          HIT_RESPAWN = 50,
    parameter int          STEP_TICKS  = 50,
    parameter int          LIFE_L0     = 5,
    parameter int          LIFE_HI     = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       run,
    input  logic [1:0] level,
    input  logic [7:0] btn_rise,
    output logic [7:0] holes_occ,
    output logic       spawn_pulse,
    output logic [2:0] spawn_idx,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       expire_pulse,
    output logic [1:0] state_o
);

    localparam logic [8:0] IVL0     = 9'(SPAWN_L0);
    localparam logic [8:0] IVL1     = 9'(SPAWN_L1);
    localparam logic [8:0] IVL2     = 9'(SPAWN_L2);
    localparam logic [8:0] HIT_LAST = 9'(HIT_RESPAWN - 1);
    localparam logic [8:0] STEP_LAST = 9'(STEP_TICKS - 1);

    state_t      state;
    logic [2:0]  life [8];
    logic [8:0]  spawn_cnt;
    logic [8:0]  step_cnt;
    logic        hit_flag;
    logic        tick_pend;
    logic [2:0]  probe_idx;
    logic [3:0]  probe_n;
    logic [2:0]  lfsr_idx;

    logic [7:0]  occ;
    logic [7:0]  last_life;
    logic [7:0]  hit_m;
    logic [7:0]  miss_m;
    logic        eff_tick;
    logic        step_wrap;
    logic        decay;
    logic [8:0]  spawn_last;
    logic        due;
    logic [2:0]  life_new;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .tap   (lfsr_idx)
    );

    always_comb begin
        occ       = '0;
        last_life = '0;
        for (int i = 0; i < 8; i++) begin
            occ[i]       = |life[i];
            last_life[i] = (life[i] == 3'd1);
        end
    end

    // presses are judged against lifetimes before this clk's update
    assign hit_m      = btn_rise & occ;
    assign miss_m     = btn_rise & ~occ;
    assign eff_tick   = tick | tick_pend;
    assign step_wrap  = (step_cnt == STEP_LAST);
    assign decay      = eff_tick & step_wrap;
    assign spawn_last = hit_flag ? HIT_LAST
                      : spawn_interval(level, IVL0, IVL1, IVL2) - 9'd1;
    assign due        = eff_tick && (spawn_cnt >= spawn_last) && (hit_m == '0);
    assign life_new   = (level == 2'd0) ? 3'(LIFE_L0) : 3'(LIFE_HI);

    assign holes_occ = occ;
    assign state_o   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            for (int i = 0; i < 8; i++) life[i] <= '0;
            spawn_cnt    <= '0;
            step_cnt     <= '0;
            hit_flag     <= 1'b0;
            tick_pend    <= 1'b0;
            probe_idx    <= '0;
            probe_n      <= '0;
            spawn_idx    <= '0;
            spawn_pulse  <= 1'b0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            spawn_pulse  <= 1'b0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            expire_pulse <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                for (int i = 0; i < 8; i++) life[i] <= '0;
                tick_pend <= 1'b0;
            end else if (start) begin
                state     <= S_RUN;
                for (int i = 0; i < 8; i++) life[i] <= '0;
                spawn_cnt <= '0;
                step_cnt  <= '0;
                hit_flag  <= 1'b1;
                tick_pend <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                    end
                    S_PAUSE: begin
                        if (run) state <= S_RUN;
                    end
                    S_RUN: begin
                        if (!run) begin
                            state <= S_PAUSE;
                        end else begin
                            tick_pend    <= 1'b0;
                            hit_pulse    <= |hit_m;
                            miss_pulse   <= |miss_m;
                            expire_pulse <= decay && |(last_life & ~btn_rise);
                            for (int i = 0; i < 8; i++) begin
                                if (hit_m[i]) life[i] <= '0;
                                else if (decay && occ[i]) life[i] <= life[i] - 3'd1;
                            end
                            if (|hit_m) begin
                                spawn_cnt <= '0;
                                step_cnt  <= '0;
                                hit_flag  <= 1'b1;
                            end else if (eff_tick) begin
                                step_cnt <= step_wrap ? 9'd0 : step_cnt + 9'd1;
                                if (due) begin
                                    spawn_cnt <= '0;
                                    hit_flag  <= 1'b0;
                                    probe_idx <= lfsr_idx;
                                    probe_n   <= '0;
                                    state     <= S_PROBE;
                                end else begin
                                    spawn_cnt <= spawn_cnt + 9'd1;
                                end
                            end
                        end
                    end
                    S_PROBE: begin
                        if (tick) tick_pend <= 1'b1;
                        hit_pulse  <= |hit_m;
                        miss_pulse <= |miss_m;
                        for (int i = 0; i < 8; i++) begin
                            if (hit_m[i]) life[i] <= '0;
                        end
                        if (|hit_m) begin
                            spawn_cnt <= '0;
                            step_cnt  <= '0;
                            hit_flag  <= 1'b1;
                        end
                        if (!occ[probe_idx]) begin
                            life[probe_idx] <= life_new;
                            spawn_idx       <= probe_idx;
                            spawn_pulse     <= 1'b1;
                            state           <= S_RUN;
                        end else begin
                            probe_idx <= probe_idx + 3'd1;
                            probe_n   <= probe_n + 4'd1;
                            if (probe_n == 4'd7) state <= S_RUN;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Sequences mole appearances across the 8 holes of the hit-the-mouse game. Owns hole occupancy and per-hole lifetime counters, picks spawn holes from a free-running LFSR, and classifies button presses as hits or misses. The score/life logic consumes its pulse outputs, and the LED driver consumes its occupancy vector. Paced by a 100 Hz single-cycle tick enable generated from clk.

Parameters:
SPAWN_L0, 300, ticks between spawns at level 0
SPAWN_L1, 250, ticks between spawns at level 1
SPAWN_L2, 150, ticks between spawns at level 2 (level 3 is treated as level 2)
HIT_RESPAWN, 50, spawn delay in ticks after a hit
STEP_TICKS, 50, ticks per lifetime decrement
LIFE_L0, 5, initial lifetime at level 0
LIFE_HI, 4, initial lifetime at levels 1-3
LFSR_SEED, 16'hACE1, LFSR value loaded at reset (nonzero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  100 Hz enable, one clk wide
start  in  1  level-sensitive; (re)starts a round
stop  in  1  game over; returns the block to IDLE
run  in  1  1 = play, 0 = pause
level  in  2  difficulty
btn_rise  in  8  rising-edge pulses per hole, already edge-detected
holes_occ  out  8  bit i = 1 when hole i lifetime != 0
spawn_pulse  out  1  one clk; a mole was committed
spawn_idx  out  3  hole index of the last spawn; held between spawns
hit_pulse  out  1  one clk; at least one press landed on an occupied hole
miss_pulse  out  1  one clk; at least one press landed on an empty hole
expire_pulse  out  1  one clk; at least one lifetime went 1->0 by decay
state_o  out  2  0 = IDLE, 1 = RUN, 2 = PROBE, 3 = PAUSE

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; all lifetimes 0; all counters 0; hit_flag 0; all pulses 0; spawn_idx 0; LFSR = LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clk in every state except during reset.
- IDLE: buttons ignored. When start = 1: go to RUN, clear lifetimes and counters, set hit_flag = 1. First spawn occurs HIT_RESPAWN ticks later.
- RUN, on tick:
  - Increment spawn_cnt and step_cnt.
  - If step_cnt == STEP_TICKS-1: clear step_cnt and decrement every nonzero lifetime. Any 1->0 transition asserts expire_pulse.
  - If spawn_cnt == interval(level)-1, or (hit_flag and spawn_cnt == HIT_RESPAWN-1): clear spawn_cnt and hit_flag, latch probe_idx = LFSR[2:0] and probe_n = 0, then go to PROBE.
- PROBE, one hole per clk:
  - If hole probe_idx is free: set its lifetime to LIFE_L0 or LIFE_HI per level, set spawn_idx, pulse spawn_pulse, go to RUN.
  - Otherwise: probe_idx += 1 mod 8 and probe_n += 1.
  - If probe_n reaches 8 (all holes full): no spawn, go to RUN.
  - A tick arriving during PROBE sets tick_pend. RUN consumes tick_pend on its next clk as if it were a tick. At most one tick is pending.
- Buttons, in RUN and PROBE, evaluated every clk against the lifetimes before that clk's update:
  - Occupied hole: lifetime becomes 0, hit_pulse = 1, spawn_cnt = 0, step_cnt = 0, hit_flag = 1.
  - Empty hole: miss_pulse = 1.
  - Several presses in one clk give a single hit_pulse and/or a single miss_pulse. Both may assert together.
- Simultaneous events:
  - A press and a spawn commit on the same hole in the same clk: the press is a miss and the spawn commits.
  - A press and a decay expiry on the same hole in the same clk: the press is a hit and expire_pulse is not asserted for that hole.
- PAUSE: entered from RUN when run = 0. Counters and lifetimes are frozen, ticks and buttons are ignored, and no tick is pended. Returns to RUN when run = 1. PROBE completes before PAUSE is honoured.
- Priority when several controls are active: stop first; then start (restart from any state, same clearing as from IDLE); then run. stop clears lifetimes and returns to IDLE.
- Counters are 9 bits wide with no wrap beyond the compare. A level change mid-round takes effect at the next compare; if spawn_cnt already exceeds the new interval-1, the spawn fires on the next tick.

Decomposition:
- Shared package: state encoding, the LFSR tap constant, and a level-to-interval function.
- Sub-module mole_lfsr: 16-bit Galois LFSR with async active-low reset and a 3-bit output tap.

Test Plan:
- reset = 0 then 1; start pulse; level 0; no presses -> first spawn_pulse on the 50th tick. Next spawn follows 300 ticks later. A lifetime-5 mole clears after 5 decrements, with expire_pulse.
- Force the LFSR to select hole 3 with holes 3 and 4 occupied -> spawn_idx = 5, committed on the 3rd PROBE clk.
- All 8 holes occupied, then spawn due -> PROBE lasts 8 clks, no spawn_pulse, back in RUN.
- Hole 2 occupied; btn_rise = 8'b0000_0101 -> hit_pulse and miss_pulse asserted in the same clk; holes_occ[2] = 0; next spawn 50 ticks later.
- run = 0 for 200 ticks mid-round -> holes_occ and counters unchanged; on resume the spawn timing continues from where it stopped.
- reset asserted during PROBE -> asynchronous return to IDLE; holes_occ = 0 and all pulses low immediately.
